// File: rtl/snoop_window_ctrl.sv
// Measurement-window controller for the packet snooper.
// Times a programmable window on a passively tapped AXI-Stream link and
// accumulates byte, flit, packet and malformed-keep totals, then offers one
// result record to the stats reader over valid/ready.
module snoop_window_ctrl #(
    parameter int TDATA_WIDTH = 128,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int CNT_WIDTH   = 32,
    parameter int WIN_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   snoop_tvalid,
    input  logic                   snoop_tready,
    input  logic [TKEEP_WIDTH-1:0] snoop_tkeep,
    input  logic                   snoop_tlast,
    input  logic [WIN_WIDTH-1:0]   cfg_window,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CNT_WIDTH-1:0]   res_bytes,
    output logic [CNT_WIDTH-1:0]   res_flits,
    output logic [CNT_WIDTH-1:0]   res_pkts,
    output logic [CNT_WIDTH-1:0]   res_bad_keep,
    output logic                   res_partial
);

    localparam int BW = $clog2(TKEEP_WIDTH + 1);
    // Sum width wide enough for either operand plus a carry bit.
    localparam int SW = ((CNT_WIDTH > BW) ? CNT_WIDTH : BW) + 1;
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, DRAIN, DONE} state_t;

    state_t                 state_q;
    logic [WIN_WIDTH-1:0]   win_cnt_q;
    logic [BW-1:0]          stage_bytes_q;
    logic                   stage_bad_q;
    logic                   in_pkt_q;
    logic                   zero_win_q;
    logic                   valid_q;
    logic                   partial_q;
    logic [CNT_WIDTH-1:0]   bytes_q, flits_q, pkts_q, bad_q;

    logic                   beat;
    logic [TKEEP_WIDTH-1:0] nkeep;
    logic                   legal;
    logic [BW-1:0]          kbytes_d;
    logic                   kbad_d;
    logic [SW-1:0]          bsum;
    logic [CNT_WIDTH-1:0]   bytes_d, flits_d, pkts_d, bad_d;

    assign beat = snoop_tvalid & snoop_tready;

    // Keep-to-byte-count conversion and saturating next values for the totals.
    always_comb begin
        nkeep = ~snoop_tkeep;
        // Low-aligned run: x & (x+1) == 0. High-aligned run: same test on ~x.
        legal = ((snoop_tkeep & (snoop_tkeep + TKEEP_WIDTH'(1))) == '0) ||
                ((nkeep & (nkeep + TKEEP_WIDTH'(1))) == '0);
        kbytes_d = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++)
            kbytes_d = kbytes_d + BW'(snoop_tkeep[i]);
        kbad_d = ~legal;
        if (!legal)
            kbytes_d = '0;

        bsum    = SW'(bytes_q) + SW'(stage_bytes_q);
        bytes_d = (bsum > SW'(CMAX)) ? CMAX : bsum[CNT_WIDTH-1:0];
        flits_d = (flits_q == CMAX) ? CMAX : flits_q + CNT_WIDTH'(1);
        pkts_d  = (pkts_q == CMAX) ? CMAX : pkts_q + CNT_WIDTH'(1);
        bad_d   = (stage_bad_q && bad_q != CMAX) ? bad_q + CNT_WIDTH'(1) : bad_q;
    end

    // Window FSM, byte stage, open-packet tracking and result registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            win_cnt_q     <= '0;
            stage_bytes_q <= '0;
            stage_bad_q   <= 1'b0;
            in_pkt_q      <= 1'b0;
            zero_win_q    <= 1'b0;
            valid_q       <= 1'b0;
            partial_q     <= 1'b0;
            bytes_q       <= '0;
            flits_q       <= '0;
            pkts_q        <= '0;
            bad_q         <= '0;
        end else begin
            // Packet framing is tracked on every beat so a window opening
            // mid-packet still knows whether a packet is open.
            if (beat)
                in_pkt_q <= ~snoop_tlast;

            if (abort && (state_q == MEASURE || state_q == DRAIN)) begin
                state_q       <= IDLE;
                win_cnt_q     <= '0;
                stage_bytes_q <= '0;
                stage_bad_q   <= 1'b0;
                partial_q     <= 1'b0;
                bytes_q       <= '0;
                flits_q       <= '0;
                pkts_q        <= '0;
                bad_q         <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            stage_bytes_q <= '0;
                            stage_bad_q   <= 1'b0;
                            partial_q     <= 1'b0;
                            bytes_q       <= '0;
                            flits_q       <= '0;
                            pkts_q        <= '0;
                            bad_q         <= '0;
                            win_cnt_q     <= cfg_window;
                            zero_win_q    <= (cfg_window == '0);
                            state_q       <= (cfg_window == '0) ? DRAIN : MEASURE;
                        end
                    end
                    MEASURE: begin
                        bytes_q       <= bytes_d;
                        bad_q         <= bad_d;
                        stage_bytes_q <= beat ? kbytes_d : '0;
                        stage_bad_q   <= beat & kbad_d;
                        if (beat) begin
                            flits_q <= flits_d;
                            if (snoop_tlast)
                                pkts_q <= pkts_d;
                        end
                        win_cnt_q <= win_cnt_q - WIN_WIDTH'(1);
                        if (win_cnt_q == WIN_WIDTH'(1))
                            state_q <= DRAIN;
                    end
                    DRAIN: begin
                        // Flush the last staged beat; beats now are outside the window.
                        bytes_q       <= bytes_d;
                        bad_q         <= bad_d;
                        stage_bytes_q <= '0;
                        stage_bad_q   <= 1'b0;
                        partial_q     <= in_pkt_q & ~zero_win_q;
                        valid_q       <= 1'b1;
                        state_q       <= DONE;
                    end
                    DONE: begin
                        if (res_ready) begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign res_valid    = valid_q;
    assign res_bytes    = bytes_q;
    assign res_flits    = flits_q;
    assign res_pkts     = pkts_q;
    assign res_bad_keep = bad_q;
    assign res_partial  = partial_q;

endmodule

// File: tb/tb_snoop_window_ctrl.sv
// Scoreboard bench for snoop_window_ctrl: stimulus pushes expected records,
// per-instance monitors pop and compare on each result handshake.
module tb_snoop_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic areset;

    // Instance A: default widths
    logic        snoop_tvalid, snoop_tready, snoop_tlast, start, abort, res_ready;
    logic [15:0] snoop_tkeep;
    logic [31:0] cfg_window;
    logic        busy, res_valid, res_partial;
    logic [31:0] res_bytes, res_flits, res_pkts, res_bad_keep;

    // Instance B: 4-bit counters for saturation
    logic        b_tvalid, b_tlast, b_start;
    logic [15:0] b_tkeep;
    logic [31:0] b_cfg;
    logic        b_busy, b_valid, b_partial;
    logic [3:0]  b_bytes, b_flits, b_pkts, b_bad;

    snoop_window_ctrl dut_a (
        .clk(clk), .areset(areset),
        .snoop_tvalid(snoop_tvalid), .snoop_tready(snoop_tready),
        .snoop_tkeep(snoop_tkeep), .snoop_tlast(snoop_tlast),
        .cfg_window(cfg_window), .start(start), .abort(abort),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_bytes(res_bytes), .res_flits(res_flits), .res_pkts(res_pkts),
        .res_bad_keep(res_bad_keep), .res_partial(res_partial)
    );

    snoop_window_ctrl #(.CNT_WIDTH(4)) dut_b (
        .clk(clk), .areset(areset),
        .snoop_tvalid(b_tvalid), .snoop_tready(1'b1),
        .snoop_tkeep(b_tkeep), .snoop_tlast(b_tlast),
        .cfg_window(b_cfg), .start(b_start), .abort(1'b0),
        .busy(b_busy), .res_valid(b_valid), .res_ready(1'b1),
        .res_bytes(b_bytes), .res_flits(b_flits), .res_pkts(b_pkts),
        .res_bad_keep(b_bad), .res_partial(b_partial)
    );

    typedef struct {
        int bytes;
        int flits;
        int pkts;
        int bad;
        int partial;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];
    int   checks = 0;
    int   passes = 0;
    int   busy_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic [15:0] k, input logic l);
        snoop_tvalid = v;
        snoop_tready = r;
        snoop_tkeep  = k;
        snoop_tlast  = l;
        tick();
    endtask

    task automatic push_a(input int by, input int fl, input int pk, input int bd, input int pa);
        rec_t r;
        r.bytes = by; r.flits = fl; r.pkts = pk; r.bad = bd; r.partial = pa;
        qa.push_back(r);
    endtask

    task automatic wait_drain_a(input int maxc);
        int n = 0;
        while (qa.size() > 0 && n < maxc) begin
            tick();
            n++;
        end
        chk("a_result_arrived", qa.size(), 0);
    endtask

    task automatic wait_valid_a(input int maxc);
        int n = 0;
        while (!res_valid && n < maxc) begin
            tick();
            n++;
        end
        chk("a_valid_seen", res_valid, 1);
    endtask

    always @(negedge clk) if (busy) busy_cnt++;

    // Monitor A: compare on every result handshake
    always @(negedge clk) begin : mon_a
        rec_t e;
        if (!areset && res_valid && res_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_bytes",   res_bytes,    e.bytes);
                chk("a_flits",   res_flits,    e.flits);
                chk("a_pkts",    res_pkts,     e.pkts);
                chk("a_bad",     res_bad_keep, e.bad);
                chk("a_partial", res_partial,  e.partial);
            end
        end
    end

    // Monitor B: ready is tied high
    always @(negedge clk) begin : mon_b
        rec_t e;
        if (!areset && b_valid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_bytes",   b_bytes,   e.bytes);
                chk("b_flits",   b_flits,   e.flits);
                chk("b_pkts",    b_pkts,    e.pkts);
                chk("b_bad",     b_bad,     e.bad);
                chk("b_partial", b_partial, e.partial);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rec_t rb;
        areset = 1'b1;
        snoop_tvalid = 0; snoop_tready = 0; snoop_tkeep = '0; snoop_tlast = 0;
        cfg_window = '0; start = 0; abort = 0; res_ready = 1;
        b_tvalid = 0; b_tkeep = '0; b_tlast = 0; b_cfg = '0; b_start = 0;
        #12;
        chk("rst_busy",  busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_bytes", res_bytes, 0);
        chk("rst_flits", res_flits, 0);
        #1 areset = 1'b0;
        tick();

        // 1: basic window, busy length, tready-gated beat
        push_a(40, 3, 1, 0, 0);
        snap = busy_cnt;
        cfg_window = 4; start = 1;
        tick();
        start = 0;
        drive(1, 1, 16'hFFFF, 0);
        drive(1, 1, 16'hFFFF, 0);
        drive(1, 1, 16'h00FF, 1);
        drive(1, 0, 16'hFFFF, 0);
        snoop_tvalid = 0;
        wait_drain_a(10);
        tick(); tick();
        chk("busy_cycles", busy_cnt - snap, 6);

        // 2: keep legality mix
        push_a(16, 5, 1, 2, 0);
        cfg_window = 5; start = 1;
        tick();
        start = 0;
        drive(1, 1, 16'h8000, 0);
        drive(1, 1, 16'hFFFE, 0);
        drive(1, 1, 16'h0000, 0);
        drive(1, 1, 16'h0F0F, 0);
        drive(1, 1, 16'h0101, 1);
        snoop_tvalid = 0;
        wait_drain_a(10);

        // 3: open packet at window end, DRAIN beat ignored, hold under backpressure
        res_ready = 0;
        push_a(32, 2, 1, 0, 1);
        cfg_window = 2; start = 1;
        tick();
        start = 0;
        drive(1, 1, 16'hFFFF, 1);
        drive(1, 1, 16'hFFFF, 0);
        drive(1, 1, 16'hFFFF, 1);
        snoop_tvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid",   res_valid, 1);
            chk("hold_bytes",   res_bytes, 32);
            chk("hold_flits",   res_flits, 2);
            chk("hold_partial", res_partial, 1);
        end
        @(posedge clk); #1;
        res_ready = 1;
        wait_drain_a(5);

        // 4: zero-length window; start in DONE ignored, also with res_ready
        res_ready = 0;
        push_a(0, 0, 0, 0, 0);
        cfg_window = 0; start = 1;
        tick();
        start = 0;
        wait_valid_a(5);
        cfg_window = 3; start = 1;
        drive(1, 1, 16'hFFFF, 1);
        start = 0; snoop_tvalid = 0;
        chk("done_start_busy",  busy, 1);
        chk("done_start_valid", res_valid, 1);
        chk("done_start_flits", res_flits, 0);
        start = 1; res_ready = 1;
        tick();
        start = 0;
        chk("done_ready_start_busy", busy, 0);
        chk("a_zero_result_popped", qa.size(), 0);

        // 5: abort on 3rd MEASURE cycle, then a fresh window
        cfg_window = 8; start = 1;
        tick();
        start = 0;
        drive(1, 1, 16'hFFFF, 0);
        drive(1, 1, 16'hFFFF, 0);
        abort = 1;
        drive(0, 1, 16'h0000, 0);
        abort = 0;
        chk("abort_busy",  busy, 0);
        chk("abort_bytes", res_bytes, 0);
        chk("abort_flits", res_flits, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_valid", res_valid, 0);
            tick();
        end
        push_a(12, 2, 2, 0, 0);
        cfg_window = 2; start = 1;
        tick();
        start = 0;
        drive(1, 1, 16'h000F, 1);
        drive(1, 1, 16'h00FF, 1);
        snoop_tvalid = 0;
        wait_drain_a(10);

        // 6: asynchronous reset mid-MEASURE
        cfg_window = 10; start = 1;
        tick();
        start = 0;
        drive(1, 1, 16'hFFFF, 0);
        drive(1, 1, 16'hFFFF, 0);
        snoop_tvalid = 0;
        chk("pre_rst_flits", res_flits, 2);
        #3 areset = 1'b1;
        #1;
        chk("arst_busy",  busy, 0);
        chk("arst_valid", res_valid, 0);
        chk("arst_bytes", res_bytes, 0);
        chk("arst_flits", res_flits, 0);
        #2 areset = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);

        // 7: saturation on 4-bit counters
        rb.bytes = 15; rb.flits = 15; rb.pkts = 15; rb.bad = 0; rb.partial = 0;
        qb.push_back(rb);
        b_cfg = 22; b_start = 1;
        tick();
        b_start = 0;
        for (int i = 0; i < 20; i++) begin
            b_tvalid = 1; b_tkeep = 16'hFFFF; b_tlast = 1;
            tick();
        end
        b_tvalid = 0; b_tlast = 0;
        begin
            int n = 0;
            while (qb.size() > 0 && n < 20) begin
                tick();
                n++;
            end
        end
        chk("b_result_arrived", qb.size(), 0);

        tick(); tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
